// File: rtl/seq_detect_moore_p.sv
// Moore serial pattern detector with a programmable PAT_W-bit pattern (MSB first),
// selectable overlap, sample enable and a saturating match counter.
module seq_detect_moore_p #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int S_W  = $clog2(PAT_W + 1);
    localparam int H_W  = PAT_W - 1;
    localparam int HC_W = $clog2(PAT_W);

    logic [PAT_W-1:0] r_pat,  w_pat_next;
    logic [S_W-1:0]   r_s,    w_s_next;
    logic [H_W-1:0]   r_hist, w_hist_next;
    logic [HC_W-1:0]  r_hcnt, w_hcnt_next;
    logic [CNT_W-1:0] r_cnt,  w_cnt_next;
    logic             r_sat,  w_sat_next;

    // Newest sample at bit 0, older history bits above it.
    logic [PAT_W-1:0] w_win;
    logic [S_W-1:0]   w_fit;
    logic             w_ok;

    assign w_win = {r_hist, x};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pat  <= PATTERN;
            r_s    <= '0;
            r_hist <= '0;
            r_hcnt <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_pat  <= w_pat_next;
            r_s    <= w_s_next;
            r_hist <= w_hist_next;
            r_hcnt <= w_hcnt_next;
            r_cnt  <= w_cnt_next;
            r_sat  <= w_sat_next;
        end
    end

    always_comb begin
        w_pat_next  = r_pat;
        w_s_next    = r_s;
        w_hist_next = r_hist;
        w_hcnt_next = r_hcnt;
        w_cnt_next  = r_cnt;
        w_sat_next  = r_sat;
        w_fit       = '0;
        w_ok        = 1'b0;

        if (load) begin
            w_pat_next  = pat_in;
            w_s_next    = '0;
            w_hist_next = '0;
            w_hcnt_next = '0;
        end else if (en) begin
            // Longest suffix of the received bits (since restart) that is a pattern prefix;
            // only suffixes fully covered by valid history qualify.
            for (int k = 1; k <= PAT_W; k++) begin
                w_ok = (int'(r_hcnt) >= k - 1);
                for (int j = 0; j < k; j++) begin
                    if (w_win[j] != r_pat[PAT_W - k + j]) begin
                        w_ok = 1'b0;
                    end
                end
                if (w_ok) begin
                    w_fit = S_W'(k);
                end
            end

            w_s_next    = w_fit;
            w_hist_next = w_win[H_W-1:0];
            if (int'(r_hcnt) < H_W) begin
                w_hcnt_next = r_hcnt + HC_W'(1);
            end

            if (w_fit == S_W'(PAT_W)) begin
                if (!OVERLAP) begin
                    w_hist_next = '0;
                    w_hcnt_next = '0;
                end
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            w_sat_next = (w_cnt_next == {CNT_W{1'b1}});
        end
    end

    assign z         = (r_s == S_W'(PAT_W));
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_moore_p.sv
// Directed-vector bench for seq_detect_moore_p covering four parameter sets
// driven from one shared serial stream.
module tb_seq_detect_moore_p;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pat4 = 4'b0000;
    logic [2:0] pat3 = 3'b101;

    logic       z0, z1, z2, z3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic       s0, s1, s2, s3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_moore_p u0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat4),
        .z(z0), .match_cnt(c0), .cnt_sat(s0)
    );
    seq_detect_moore_p #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat4),
        .z(z1), .match_cnt(c1), .cnt_sat(s1)
    );
    seq_detect_moore_p #(.PAT_W(3), .PATTERN(3'b101)) u2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat3),
        .z(z2), .match_cnt(c2), .cnt_sat(s2)
    );
    seq_detect_moore_p #(.CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat4),
        .z(z3), .match_cnt(c3), .cnt_sat(s3)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic bit_in(input logic b);
        en = 1'b1; load = 1'b0; x = b;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        en = 1'b0; load = 1'b0; x = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        en = 1'b0; load = 1'b0; x = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic load_pat(input logic [3:0] p);
        en = 1'b1; load = 1'b1; x = 1'b0; pat4 = p;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    logic [6:0] st1;
    logic [6:0] ez0;
    logic [6:0] ez1;
    logic [3:0] st2;
    logic [3:0] ez2;
    logic [4:0] st3;
    logic [4:0] ez3;
    logic [1:0] exp_c3 [5];
    logic       exp_s3 [5];

    initial begin
        // Reset state
        @(posedge clk); #1;
        do_reset();
        chk("rst_z0", z0, 0);   chk("rst_cnt0", c0, 0); chk("rst_sat0", s0, 0);
        chk("rst_z1", z1, 0);   chk("rst_z2", z2, 0);   chk("rst_z3", z3, 0);
        chk("rst_cnt3", c3, 0); chk("rst_sat3", s3, 0);

        // 1101101 then 1101: overlapping vs non-overlapping
        st1 = 7'b1101101; ez0 = 7'b0001001; ez1 = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            bit_in(st1[i]);
            chk($sformatf("ov_z_b%0d", 7 - i), z0, ez0[i]);
            chk($sformatf("nov_z_b%0d", 7 - i), z1, ez1[i]);
        end
        chk("ov_cnt", c0, 2);
        chk("nov_cnt", c1, 1);
        st2 = 4'b1101; ez2 = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            bit_in(st2[i]);
            chk($sformatf("nov_z2_b%0d", 4 - i), z1, ez2[i]);
            chk($sformatf("ov_z2_b%0d", 4 - i), z0, ez2[i]);
        end
        chk("nov_cnt2", c1, 2);
        chk("ov_cnt2", c0, 3);

        // PAT_W=3 pattern 101 on 10101
        do_reset();
        st3 = 5'b10101; ez3 = 5'b00101;
        for (int i = 4; i >= 0; i--) begin
            bit_in(st3[i]);
            chk($sformatf("p3_z_b%0d", 5 - i), z2, ez3[i]);
        end
        chk("p3_cnt", c2, 2);

        // 11101 against 1101 needs the failure transition
        do_reset();
        st3 = 5'b11101; ez3 = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            bit_in(st3[i]);
            chk($sformatf("kmp_z_b%0d", 5 - i), z0, ez3[i]);
        end
        chk("kmp_cnt", c0, 1);

        // Enable gating
        do_reset();
        bit_in(1'b1); bit_in(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("en_hold_z", z0, 0);
            chk("en_hold_cnt", c0, 0);
        end
        bit_in(1'b0);
        chk("en_b3_z", z0, 0);
        bit_in(1'b1);
        chk("en_match_z", z0, 1);
        chk("en_match_cnt", c0, 1);
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("en_match_hold_z", z0, 1);
            chk("en_match_hold_cnt", c0, 1);
        end

        // Pattern load mid-stream keeps the count
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        chk("ld_pre_z", z0, 0);
        load_pat(4'b0110);
        chk("ld_z", z0, 0);
        chk("ld_cnt", c0, 1);
        st2 = 4'b0110; ez2 = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            bit_in(st2[i]);
            chk($sformatf("ld_z_b%0d", 4 - i), z0, ez2[i]);
        end
        chk("ld_cnt2", c0, 2);

        // CNT_W=2 saturation, then reset in MATCH restores the pattern
        do_reset();
        bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        exp_c3 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_s3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int m = 0; m < 5; m++) begin
            bit_in(1'b1);
            chk($sformatf("sat_z_m%0d", m + 1), z3, 1);
            chk($sformatf("sat_cnt_m%0d", m + 1), c3, exp_c3[m]);
            chk($sformatf("sat_flag_m%0d", m + 1), s3, exp_s3[m]);
            if (m < 4) begin
                bit_in(1'b1); bit_in(1'b0);
            end
        end
        load_pat(4'b0110);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
        chk("sat_ld_z", z3, 1);
        chk("sat_ld_cnt", c3, 3);
        do_reset();
        chk("midrst_z", z3, 0);
        chk("midrst_cnt", c3, 0);
        chk("midrst_sat", s3, 0);
        st2 = 4'b1101; ez2 = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            bit_in(st2[i]);
            chk($sformatf("rstpat_z_b%0d", 4 - i), z3, ez2[i]);
        end
        chk("rstpat_cnt", c3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_moore_p.md
Name: seq_detect_moore_p

Overview:
Parametrised Moore serial pattern detector, successor to the fixed 3-bit "101" detector. It watches a 1-bit serial input for a PAT_W-bit pattern, sent MSB first. The pattern is runtime-programmable, overlap mode is selectable, a sample-enable is provided, and a saturating match counter is included. It sits on serial control/data lines in the sequential-circuits library as a drop-in generalisation of the fixed detector.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
PATTERN, 4'b1101, reset value of the pattern register; MSB is the first bit expected.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history cleared after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-low.
en  input  1  sample enable; x is consumed only on edges where en=1.
x  input  1  serial data bit.
load  input  1  load pat_in into the pattern register.
pat_in  input  PAT_W  new pattern, MSB first.
z  output  1  Moore match flag (decoded from state only).
match_cnt  output  CNT_W  number of matches since reset, saturating.
cnt_sat  output  1  high when match_cnt is all ones.

Behaviour:
- One clock domain. Reset is synchronous and active-low: on any rising clk edge with rst=0, all state is reset. Reset has top priority.
- Reset values:
  - pattern register = PATTERN
  - progress state = 0
  - z = 0
  - match_cnt = 0
  - cnt_sat = 0
- State:
  - progress index s in 0..PAT_W, held in a register. s=PAT_W is the MATCH state.
  - Retain PAT_W-1 bits of sample history so the failure transitions can be computed.
- Transition on an edge with en=1 and load=0, for sampled bit x:
  - Let H = the bits received since the last restart point, with x appended.
  - s_next = length of the longest suffix of H that equals a prefix of the pattern. A result of PAT_W means a match.
  - This is KMP-equivalent. A naive reset to 0 on mismatch is non-compliant (e.g. pattern 1101 on input 11101 must match).
- Restart point:
  - OVERLAP=1: none; matches may share bits.
  - OVERLAP=0: the restart point is set immediately after the completing bit, so the next match uses only later bits.
- z = (s == PAT_W). It is purely a state decode with no combinational path from x.
- z timing:
  - z rises in the cycle after the edge that sampled the final pattern bit.
  - It lasts one cycle per match, unless consecutive edges each complete a match (e.g. pattern 1111, OVERLAP=1, input of continuous 1s keeps z high).
- en=0: s, history, z and match_cnt all hold. x is ignored.
- load=1 (priority over en):
  - pattern register <= pat_in.
  - s <= 0 and history cleared, so z=0 next cycle.
  - match_cnt is unchanged.
  - x is not sampled on that edge.
- match_cnt:
  - Increments by 1 on each edge where s_next == PAT_W, so it updates on the same edge z rises.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat = (match_cnt == all ones), registered consistently with match_cnt.
- Width rules: match_cnt is an unsigned increment. The comparison covers all PAT_W bits of the pattern register.
- Reset mid-match: everything returns to reset values on that edge, and no partial progress survives.

Test Plan:
- Default params, rst released, en=1, x = 1,1,0,1,1,0,1 on consecutive edges -> z=1 in the cycle after bit 4 and after bit 7; match_cnt=2.
- OVERLAP=0, same stream 1101101 -> z=1 only after bit 4; match_cnt=1. Then add 1,1,0,1 -> second match; match_cnt=2.
- PAT_W=3, PATTERN=3'b101, OVERLAP=1, x = 1,0,1,0,1 -> z pulses after bits 3 and 5; match_cnt=2. Stream 11101 with PATTERN 1101 -> one match, proving failure transitions.
- en toggling: 1,1,(en=0 for 3 cycles with x=0),0,1 -> match after the 4th enabled bit; z/s frozen while en=0. z held high if en drops in the MATCH state.
- load mid-stream: after 1,1,0, pulse load with pat_in=4'b0110 -> s=0, z=0. Then 0,1,1,0 -> match; match_cnt is preserved across load.
- CNT_W=2, five matches -> match_cnt stops at 3 and cnt_sat=1. Then rst=0 for one edge while in MATCH state -> z=0, match_cnt=0, cnt_sat=0, pattern register = PATTERN.
